// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a word-addressed memory; sub-word stores use read-modify-write.
// Optional macro MAU_ALIGN_CHECK_EN rejects misaligned half/word requests; undefined forces natural alignment.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_STORE  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_ERR    = 3'd5,
      S_RESP   = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rmw_q, rmw_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              req_misaligned;
   logic              req_illegal;

   // Picks the addressed lane and extends it; half lanes use addr[1] only, so alignment is implied.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = word;
      if (size == 2'b00) begin
         case (lane)
            2'b00:   r[7:0]   = data[7:0];
            2'b01:   r[15:8]  = data[7:0];
            2'b10:   r[23:16] = data[7:0];
            default: r[31:24] = data[7:0];
         endcase
      end else if (lane[1]) begin
         r[31:16] = data[15:0];
      end else begin
         r[15:0] = data[15:0];
      end
      return r;
   endfunction

`ifdef MAU_ALIGN_CHECK_EN
   assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                           ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign req_misaligned = 1'b0;
`endif
   assign req_illegal = (req_size == 2'b11) || req_misaligned;

   // State and request registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         wdata_q  <= 32'h0000_0000;
         rmw_q    <= 32'h0000_0000;
         rdata_q  <= 32'h0000_0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rmw_q    <= rmw_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Next-state and datapath capture.
   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rmw_d    = rmw_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               size_d   = req_size;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = 1'b0;
               if (req_illegal)              state_d = S_ERR;
               else if (!req_write)          state_d = S_LOAD;
               else if (req_size == 2'b10)   state_d = S_STORE;
               else                          state_d = S_RMW_RD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            rdata_d = load_extract(mem_rdata, size_q, signed_q, addr_q[1:0]);
            state_d = S_RESP;
         end
         S_STORE: begin
            rdata_d = 32'h0000_0000;
            state_d = S_RESP;
         end
         S_RMW_RD: begin
            rmw_d   = mem_rdata;
            state_d = S_RMW_WR;
         end
         S_RMW_WR: begin
            rdata_d = 32'h0000_0000;
            state_d = S_RESP;
         end
         S_ERR: begin
            rdata_d = 32'h0000_0000;
            err_d   = 1'b1;
            state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory strobes are pure state decodes so they drop together with the asynchronous reset.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 32'h0000_0000;
      case (state_q)
         S_LOAD, S_RMW_RD: begin
            mem_read = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
         end
         S_STORE: begin
            mem_write = 1'b1;
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_wdata = wdata_q;
         end
         S_RMW_WR: begin
            mem_write = 1'b1;
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_wdata = store_merge(rmw_q, wdata_q, size_q, addr_q[1:0]);
         end
         default: begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      endcase
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = (state_q == S_RESP) && err_q;
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a 16-word behavioural memory.
// Expected values are hand-computed; MAU_ALIGN_CHECK_EN selects the misaligned-load expectation.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:15];

   int          total = 0;
   int          bad = 0;

   int          lat, nrd, nwr, wr_cyc;
   logic        got, ready_acc, ready1, ready_after, quiet_after, er;
   logic [31:0] rd;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[5:2]];

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
      int cyc;
      @(negedge clk);
      ready_acc  = req_ready;
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = ~w;
      req_size   = 2'b11;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'hDEAD_BEEF;
      got = 1'b0; lat = 0; nrd = 0; nwr = 0; wr_cyc = 0; cyc = 0;
      ready1 = 1'b1; rd = 32'h0; er = 1'b0;
      while (!got && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) ready1 = req_ready;
         if (mem_read) nrd++;
         if (mem_write) begin nwr++; wr_cyc = cyc; end
         if (resp_valid) begin got = 1'b1; lat = cyc; rd = resp_rdata; er = resp_err; end
      end
      @(negedge clk);
      ready_after = req_ready;
      quiet_after = !(mem_read || mem_write || (mem_addr != 32'h0) || (mem_wdata != 32'h0) || resp_valid);
   endtask

   task automatic chk_resp(input string tag, input int exp_lat, input logic [31:0] exp_rd,
                           input logic exp_er);
      check({tag, "_seen"}, {31'h0, got}, 32'h1);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, {31'h0, er}, {31'h0, exp_er});
      check({tag, "_ready_acc"}, {31'h0, ready_acc}, 32'h1);
      check({tag, "_ready_busy"}, {31'h0, ready1}, 32'h0);
      check({tag, "_ready_after"}, {31'h0, ready_after}, 32'h1);
      check({tag, "_idle_quiet"}, {31'h0, quiet_after}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0000_0001;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_err", {31'h0, resp_err}, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_mem", {mem_read, mem_write, 30'h0}, 32'h0);
      check("rst_maddr", mem_addr, 32'h0);
      check("rst_mwdata", mem_wdata, 32'h0);
      reset = 1'b0;

      do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      chk_resp("ld_w4", 2, 32'h0000_0001, 1'b0);
      check("ld_w4_nrd", nrd, 1);
      check("ld_w4_nwr", nwr, 0);
      repeat (2) @(negedge clk);
      check("rdata_hold", resp_rdata, 32'h0000_0001);

      do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
`ifdef MAU_ALIGN_CHECK_EN
      chk_resp("ld_w5", 2, 32'h0, 1'b1);
      check("ld_w5_nrd", nrd, 0);
`else
      chk_resp("ld_w5", 2, 32'h0000_0001, 1'b0);
      check("ld_w5_nrd", nrd, 1);
`endif

      do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678);
      chk_resp("st_w8", 2, 32'h0, 1'b0);
      check("st_w8_nwr", nwr, 1);
      check("st_w8_nrd", nrd, 0);
      check("st_w8_mem", mem[2], 32'h1234_5678);

      do_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0);
      chk_resp("ld_bs_b", 2, 32'h0000_0012, 1'b0);
      do_req(1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
      chk_resp("ld_bu_8", 2, 32'h0000_0078, 1'b0);
      do_req(1'b0, 2'b00, 1'b1, 32'hA, 32'h0);
      chk_resp("ld_bs_a", 2, 32'h0000_0034, 1'b0);

      do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h5555_55AB);
      chk_resp("st_b9", 3, 32'h0, 1'b0);
      check("st_b9_nwr", nwr, 1);
      check("st_b9_wrcyc", wr_cyc, 2);
      check("st_b9_nrd", nrd, 1);
      check("st_b9_mem", mem[2], 32'h1234_AB78);

      do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
      chk_resp("ld_bs_9", 2, 32'hFFFF_FFAB, 1'b0);
      do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
      chk_resp("ld_bu_9", 2, 32'h0000_00AB, 1'b0);

      do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'hCDEF_8001);
      chk_resp("st_h6", 3, 32'h0, 1'b0);
      check("st_h6_mem", mem[1], 32'h8001_0001);
      do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
      chk_resp("ld_hs_6", 2, 32'hFFFF_8001, 1'b0);
      do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
      chk_resp("ld_hu_6", 2, 32'h0000_8001, 1'b0);
      do_req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0);
      chk_resp("ld_hs_4", 2, 32'h0000_0001, 1'b0);

      do_req(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
      chk_resp("ld_rsv", 2, 32'h0, 1'b1);
      check("ld_rsv_strobes", nrd + nwr, 0);
      do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFF_FFFF);
      chk_resp("st_rsv", 2, 32'h0, 1'b1);
      check("st_rsv_mem", mem[2], 32'h1234_AB78);

      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h8; req_wdata = 32'h0000_00CD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("abort_rmw_rd", {31'h0, mem_read}, 32'h1);
      @(negedge clk);
      check("abort_rmw_wr", {31'h0, mem_write}, 32'h1);
      check("abort_rmw_wdata", mem_wdata, 32'h1234_ABCD);
      #1 reset = 1'b1;
      #1;
      check("abort_wr_drop", {31'h0, mem_write}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("abort_mem", mem[2], 32'h1234_AB78);
      check("abort_ready", {31'h0, req_ready}, 32'h1);
      check("abort_rdata", resp_rdata, 32'h0);
      check("abort_outs", {mem_read, mem_write, resp_valid, resp_err, 28'h0}, 32'h0);
      check("abort_maddr", mem_addr, 32'h0);
      nrd = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) nrd++;
      end
      check("abort_no_resp", nrd, 0);

      do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      chk_resp("ld_after_abort", 2, 32'h1234_AB78, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the pipeline MEM stage and the word-addressed data memory. It accepts one load or store request at a time and drives the memory's `MemRead`/`MemWrite`/`addr`/`write_data` side. It supports byte, halfword and word accesses:
- sub-word loads are extracted and sign- or zero-extended;
- sub-word stores are performed as a read-modify-write of the containing word.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width; memory word index is `addr[ADDR_W-1:2]`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  `00` byte, `01` half, `10` word, `11` reserved.
- `req_signed`  in  1  sign-extend loads (ignored for word loads and stores).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores; holds between responses.
- `resp_err`  out  1  qualifies `resp_valid`; access was rejected.
- `mem_read`  out  1  to memory `MemRead`.
- `mem_write`  out  1  to memory `MemWrite`.
- `mem_addr`  out  ADDR_W  word-aligned: `{req_addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata`  out  32  to memory `write_data`.
- `mem_rdata`  in  32  from memory `read_data` (combinational, same cycle).

## Operation
- Little-endian lanes: byte k = bits [8k+7:8k], selected by `addr[1:0]`; half lane selected by `addr[1]`.
- A request is accepted on a rising edge with `req_valid && req_ready`. All request fields are latched. Inputs are ignored at all other times.
- States:
  - IDLE: `req_ready` = 1.
  - LOAD: `mem_read` = 1; the selected lane is extracted and extended into `resp_rdata` at the cycle end. Next state RESP.
  - STORE (word): `mem_write` = 1, `mem_wdata` = latched data. Next state RESP.
  - RMW_RD (byte/half store): `mem_read` = 1; the word is captured into an internal register. Next state RMW_WR.
  - RMW_WR: `mem_write` = 1; `mem_wdata` = captured word with only the target lane replaced. Next state RESP.
  - ERR: single cycle, no memory strobes. Next state RESP with the error flag set.
  - RESP: `resp_valid` = 1. Next state IDLE.
- Illegal requests go to ERR: `req_size = 11`, plus misalignment when the macro is defined.
- `mem_read` and `mem_write` are never high together.
- Outside the access states, `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are all 0.
- Extension rules:
  - Byte signed: replicate bit 7.
  - Half signed: replicate bit 15.
  - Unsigned: zero-fill.
- Reset values: state IDLE; `req_ready` = 1; `resp_valid` = 0; `resp_err` = 0; `resp_rdata` = 0; every `mem_*` output = 0.
- Reset mid-operation aborts the access. `mem_write` falls asynchronously with `reset`, so no partial write is issued after assertion. No response is produced for the aborted request.

## Timing
- Accept at edge T.
- Word load/store and sub-word load: access cycle T+1, `resp_valid` in cycle T+2.
- Sub-word store: RMW_RD T+1, RMW_WR T+2, `resp_valid` T+3.
- Error: ERR T+1, `resp_valid` T+2.
- `req_ready` is low from T+1 through the RESP cycle and returns high the cycle after RESP. Throughput is one request per 3 cycles (4 for sub-word stores).
- `resp_valid` is never held for more than one cycle; there is no response backpressure.

## Configuration
- `MAU_ALIGN_CHECK_EN` defined: misaligned requests are routed to ERR. Misaligned means a half with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0. They give `resp_err` = 1 and `resp_rdata` = 0, and no memory strobe is issued.
- Undefined: low address bits below the access size are ignored; the access is forced to natural alignment. `resp_err` is set only for `req_size = 11`.

## Test plan
- Memory preloaded with word1 = 1. Word load at 0x4 -> `resp_valid` exactly 2 cycles after accept, `resp_rdata` = 0x00000001, `resp_err` = 0.
- Word store 0x12345678 at 0x8. Then signed byte load at 0xB -> 0x00000012; unsigned byte load at 0x8 -> 0x00000078.
- Byte store 0xAB at 0x9 over word 0x12345678 -> word becomes 0x1234AB78, `mem_write` high exactly one cycle (T+2). A following signed byte load at 0x9 -> 0xFFFFFFAB.
- Half store 0x8001 at 0x6 over word 0x00000001 -> word becomes 0x80010001. Signed half load at 0x6 -> 0xFFFF8001; unsigned -> 0x00008001.
- Word load at 0x5:
  - With `MAU_ALIGN_CHECK_EN`: `resp_err` = 1, `resp_rdata` = 0, `mem_read` never high.
  - Without: returns word1 = 0x00000001.
- `reset` pulsed during RMW_WR of a byte store at 0x8 -> `mem_write` drops with `reset`, target word unchanged, `req_ready` = 1 and all outputs at reset values after release.
